// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose: bridges a 32-bit MEM-stage load/store onto a 16-bit asynchronous
// SRAM. Each access runs as two half-word transfers (low half, then high half).
// Each half lasts WAIT_CYCLES+1 clocks. The pipeline is frozen until the
// single-cycle ready pulse.
//
// Parameters:
//   WAIT_CYCLES  extra SRAM wait cycles per half-access (0..7)
//   BASE_ADDR    byte address that maps to SRAM half-word 0
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   mem_r_en     load request
//   mem_w_en     store request (wins when both enables are high)
//   alu_result   byte address of the access
//   st_val       store data
//   freeze       pipeline stall, combinational
//   ready        one-cycle pulse when the access completes
//   rd_data      load result, held until the next load
//   err          one-cycle pulse with ready for an out-of-range access
//   sram_addr    SRAM half-word address
//   sram_wdata   SRAM write data
//   sram_rdata   SRAM read data
//   sram_we_n    SRAM write strobe, active low
//   sram_oe_n    SRAM output enable, active low
//
// Optional feature: define MEM_ACCESS_CTRL_BOUNDS_CHECK_EN to enable the
// range check. Addresses outside [BASE_ADDR, BASE_ADDR+2^19-1] then finish
// immediately with err and no SRAM activity. Without the macro, the word
// index simply wraps and err is always 0.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] st_val,
    output logic        freeze,
    output logic        ready,
    output logic [31:0] rd_data,
    output logic        err,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [16:0] idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [31:0] st_val_q, st_val_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic        sram_oe_n_q, sram_oe_n_d;
    logic        in_xfer;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
    logic        oor_q, oor_d;
`endif

    // Next-state logic. The request, address, direction and store data are
    // latched only when leaving IDLE, so the access in flight ignores later
    // input changes. The SRAM outputs are computed from the *next* state,
    // so they come straight from flops and line up with the state register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        st_val_d  = st_val_q;
        rd_data_d = rd_data_q;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
        oor_d     = oor_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (mem_r_en || mem_w_en) begin
                    idx_d    = 17'((alu_result - BASE_ADDR) >> 2);
                    wr_d     = mem_w_en;
                    st_val_d = st_val;
                    cnt_d    = 3'd0;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
                    oor_d    = (alu_result < BASE_ADDR) ||
                               ((alu_result - BASE_ADDR) >= 32'h0008_0000);
                    state_d  = oor_d ? S_DONE : S_LO;
`else
                    state_d  = S_LO;
`endif
                end
            end
            S_LO: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = S_HI;
                    if (!wr_q) begin
                        rd_data_d[15:0] = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HI: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rd_data_d[31:16] = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_xfer      = (state_d == S_LO) || (state_d == S_HI);
        sram_addr_d  = in_xfer ? {idx_d, (state_d == S_HI)} : 18'd0;
        sram_wdata_d = 16'd0;
        if (in_xfer && wr_d) begin
            sram_wdata_d = (state_d == S_HI) ? st_val_d[31:16] : st_val_d[15:0];
        end
        // Only one strobe can be active at a time, because direction is a single bit.
        sram_we_n_d  = ~(in_xfer & wr_d);
        sram_oe_n_d  = ~(in_xfer & ~wr_d);
        ready_d      = (state_d == S_DONE);
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
        err_d        = ready_d & oor_d;
`else
        err_d        = 1'b0;
`endif
    end

    // State and registered outputs. Reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            idx_q        <= 17'd0;
            wr_q         <= 1'b0;
            st_val_q     <= 32'd0;
            rd_data_q    <= 32'd0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            sram_addr_q  <= 18'd0;
            sram_wdata_q <= 16'd0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
            oor_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wr_q         <= wr_d;
            st_val_q     <= st_val_d;
            rd_data_q    <= rd_data_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
            oor_q        <= oor_d;
`endif
        end
    end

    assign freeze     = (mem_r_en | mem_w_en) & ~ready_q;
    assign ready      = ready_q;
    assign err        = err_q;
    assign rd_data    = rd_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Purpose: self-checking bench for mem_access_ctrl. A behavioural SRAM sits
// behind the main instance (WAIT_CYCLES=1). A scoreboard queue holds the
// expected latency, err and rd_data of every access. Entries are pushed
// when a request is driven and popped when ready pulses. A second instance
// (WAIT_CYCLES=0) covers back-to-back loads. The bench honours
// MEM_ACCESS_CTRL_BOUNDS_CHECK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int          W    = 1;
    localparam logic [31:0] BASE = 32'd1024;

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] alu_result, st_val;
    logic        freeze, ready, err;
    logic [31:0] rd_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_we_n, sram_oe_n;

    logic        r2, w2;
    logic [31:0] alu2, st2;
    logic        freeze2, ready2, err2;
    logic [31:0] rd2;
    logic [17:0] addr2;
    logic [15:0] wdata2, rdata2;
    logic        we_n2, oe_n2;

    logic [15:0] sram_mem [128];
    logic        clear_mem;
    logic [31:0] model_mem [64];
    logic [31:0] last_rd;
    logic        watch_oe;
    exp_t        sb [$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result(alu_result), .st_val(st_val), .freeze(freeze),
        .ready(ready), .rd_data(rd_data), .err(err), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut_w0 (
        .clk(clk), .rst(rst), .mem_r_en(r2), .mem_w_en(w2),
        .alu_result(alu2), .st_val(st2), .freeze(freeze2),
        .ready(ready2), .rd_data(rd2), .err(err2), .sram_addr(addr2),
        .sram_wdata(wdata2), .sram_rdata(rdata2),
        .sram_we_n(we_n2), .sram_oe_n(oe_n2)
    );

    // Behavioural SRAM for the main instance. It is written while we_n is
    // low and read combinationally while oe_n is low.
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 128; i++) sram_mem[i] <= 16'h0;
        end else if (!sram_we_n) begin
            sram_mem[sram_addr[6:0]] <= sram_wdata;
        end
    end
    assign sram_rdata = sram_oe_n ? 16'h0 : sram_mem[sram_addr[6:0]];

    // The second instance reads a fixed pattern derived from the address.
    assign rdata2 = oe_n2 ? 16'h0 : (addr2[15:0] ^ {14'h0, addr2[17:16]} ^ 16'h5A5A);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: strobe exclusivity every cycle, and each ready is
    // matched against the oldest expected access.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("we_oe_excl", 32'(sram_we_n | sram_oe_n), 32'd1);
            if (watch_oe) checkOutput("oe_n_store", 32'(sram_oe_n), 32'd1);
            if (ready) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_ready", 32'(ready), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("latency", 32'(cyc - e.start), 32'(e.lat));
                    checkOutput("err", 32'(err), 32'(e.err));
                    checkOutput("rd_data", rd_data, e.rd);
                end
            end
        end
    end

    task automatic pushExpect(input logic w, input logic [31:0] addr, input logic [31:0] val);
        exp_t e;
        int   slot;
        e.start = cyc;
        slot    = int'(((addr - BASE) >> 2) & 32'd63);
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
        if ((addr < BASE) || ((addr - BASE) >= 32'h0008_0000)) begin
            e.lat = 1;
            e.err = 1'b1;
            e.rd  = last_rd;
            sb.push_back(e);
            return;
        end
`endif
        e.lat = 2 * W + 3;
        e.err = 1'b0;
        if (w) begin
            model_mem[slot] = val;
            e.rd = last_rd;
        end else begin
            e.rd    = model_mem[slot];
            last_rd = e.rd;
        end
        sb.push_back(e);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Drives a single-cycle request, then scrambles the inputs while the
    // access is still in flight.
    task automatic applyStimulus(input bit sync, input logic r, input logic w,
                                 input logic [31:0] addr, input logic [31:0] val);
        if (sync) begin
            @(posedge clk);
            #1;
        end
        mem_r_en   = r;
        mem_w_en   = w;
        alu_result = addr;
        st_val     = val;
        pushExpect(w, addr, val);
        @(posedge clk);
        #1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = $urandom;
        st_val     = $urandom;
        waitDrain();
    endtask

    task automatic resetChecks(input string pfx);
        checkOutput({pfx, "_ready"}, 32'(ready), 32'd0);
        checkOutput({pfx, "_err"}, 32'(err), 32'd0);
        checkOutput({pfx, "_addr"}, 32'(sram_addr), 32'd0);
        checkOutput({pfx, "_wdata"}, 32'(sram_wdata), 32'd0);
        checkOutput({pfx, "_we_n"}, 32'(sram_we_n), 32'd1);
        checkOutput({pfx, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        checkOutput({pfx, "_rd_data"}, rd_data, 32'd0);
    endtask

    // Store of 0xDEADBEEF at 1032, with the request held through DONE:
    // the SRAM waveform and freeze are checked cycle by cycle.
    task automatic storeTrace();
        logic [17:0] ea [6];
        logic [15:0] ed [6];
        logic        ew [6];
        logic        ef [6];
        ea = '{18'd0, 18'd4, 18'd4, 18'd5, 18'd5, 18'd0};
        ed = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
        ew = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ef = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        @(posedge clk);
        #1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b1;
        alu_result = 32'd1032;
        st_val     = 32'hDEADBEEF;
        pushExpect(1'b1, 32'd1032, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("trace_addr_c%0d", c), 32'(sram_addr), 32'(ea[c]));
            checkOutput($sformatf("trace_wdata_c%0d", c), 32'(sram_wdata), 32'(ed[c]));
            checkOutput($sformatf("trace_we_n_c%0d", c), 32'(sram_we_n), 32'(ew[c]));
            checkOutput($sformatf("trace_oe_n_c%0d", c), 32'(sram_oe_n), 32'd1);
            checkOutput($sformatf("trace_freeze_c%0d", c), 32'(freeze), 32'(ef[c]));
            @(posedge clk);
            #1;
        end
        mem_w_en = 1'b0;
        waitDrain();
    endtask

    task automatic backToBack();
        int er [8];
        er = '{0, 0, 0, 1, 0, 0, 0, 1};
        @(posedge clk);
        #1;
        r2   = 1'b1;
        alu2 = 32'd1036;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_ready_c%0d", c), 32'(ready2), 32'(er[c]));
            checkOutput($sformatf("b2b_we_n_c%0d", c), 32'(we_n2), 32'd1);
            checkOutput($sformatf("b2b_wdata_c%0d", c), 32'(wdata2), 32'd0);
            if (c == 0) checkOutput("b2b_freeze", 32'(freeze2), 32'd1);
            if (er[c] == 1) begin
                checkOutput("b2b_rd_data", rd2, 32'h5A5D5A5C);
                checkOutput("b2b_err", 32'(err2), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        r2 = 1'b0;
    endtask

    initial begin
        logic [31:0] a, v;
        rst        = 1'b0;
        clear_mem  = 1'b1;
        watch_oe   = 1'b0;
        last_rd    = 32'd0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = 32'd0;
        st_val     = 32'd0;
        r2         = 1'b0;
        w2         = 1'b0;
        alu2       = 32'd0;
        st2        = 32'd0;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetChecks("reset");
        checkOutput("reset_freeze", 32'(freeze), 32'd0);
        @(posedge clk);
        #1;
        clear_mem = 1'b0;
        rst       = 1'b1;

        storeTrace();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
        watch_oe = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd1024, 32'h12345678);
        watch_oe = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0);

        for (int i = 0; i < 6; i++) begin
            a = BASE + 32'(4 * $urandom_range(0, 63));
            v = $urandom;
            applyStimulus(1'b1, 1'b0, 1'b1, a, v);
            a = BASE + 32'(4 * $urandom_range(0, 63));
            applyStimulus(1'b1, 1'b1, 1'b0, a, 32'd0);
        end

        // Out-of-range load at address 0. The index wraps onto the same
        // slot as 1024 unless the range check is built in.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);

        // Reset while the store is in its low half.
        @(posedge clk);
        #1;
        mem_w_en   = 1'b1;
        alu_result = 32'd1040;
        st_val     = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_w_en = 1'b0;
        @(negedge clk);
        resetChecks("midreset");
        @(posedge clk);
        #1;
        rst     = 1'b1;
        last_rd = 32'd0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);

        backToBack();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
